// File: rtl/uart_rx_fifo.sv
// Generic single-clock FIFO: first-word-fall-through read, write accepted when not full or when popped the same cycle.
// Latency: a write is visible on rd_dat/rd_vld the clock after it is accepted.
// Backpressure: a write into a full FIFO without a concurrent pop is dropped and flagged on wr_drop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n_i,
    input  logic                         wr_vld,
    input  logic [WIDTH-1:0]             wr_dat,
    input  logic                         rd_rdy,
    output logic                         rd_vld,
    output logic [WIDTH-1:0]             rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         wr_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pop, full, wr_ok;

    assign rd_vld = (cnt_q != '0);
    assign count  = cnt_q;
    // Empty FIFO presents zero rather than stale (unreset) storage.
    assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        pop      = rd_vld && rd_rdy;
        full     = (cnt_q == CW'(DEPTH));
        wr_ok    = wr_vld && (!full || pop);
        wr_drop  = wr_vld && full && !pop;
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !wr_ok)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem_q[wr_ptr_q] <= wr_dat;
    end
endmodule

// UART 8N1 receiver feeding a byte FIFO, with hysteretic RTS throttling of the host.
// Latency: byte on data_o one clock after the stop-bit sample (~9.5 bit times + 3 clocks from start edge).
// Backpressure: rts_o asserts with RTS_MARGIN slots free; bytes arriving into a full FIFO are dropped and latch overrun_o.
module uart_rx_fifo #(
    parameter int FREQ_HZ    = 16000000,
    parameter int BAUDS      = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                              clk,
    input  logic                              reset_n_i,
    input  logic                              rx_i,
    output logic                              rts_o,
    output logic [7:0]                        data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              frame_err_o,
    output logic                              overrun_o,
    input  logic                              clear_i
);
    localparam int CLKS_PER_BIT = FREQ_HZ / BAUDS;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT/2 - 1);
    localparam logic [TW-1:0] T_WRAP = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          rx_s1_q, rx_s2_q, rxs;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rts_q, rts_d;
    logic          push, stop_smp, drop;
    logic [CW-1:0] cnt;

    assign rxs = rx_s2_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rts_q   <= 1'b1;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            rts_q   <= rts_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rxs)
                    state_d = START;
            end
            START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == T_WRAP) begin
                    timer_d = '0;
                    shreg_d = {rxs, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so an immediately following start edge is seen.
                if (timer_q == T_WRAP) begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stop_smp = (state_q == STOP) && (timer_q == T_WRAP);
        push     = stop_smp && rxs;
        ferr_d   = stop_smp && !rxs;
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .wr_vld    (push),
        .wr_dat    (shreg_q),
        .rd_rdy    (ready_i),
        .rd_vld    (valid_o),
        .rd_dat    (data_o),
        .count     (cnt),
        .wr_drop   (drop)
    );

    always_comb begin
        ovr_d = ovr_q;
        if (drop)
            ovr_d = 1'b1;
        else if (clear_i)
            ovr_d = 1'b0;
        rts_d = rts_q;
        if (cnt >= CW'(FIFO_DEPTH - RTS_MARGIN))
            rts_d = 1'b1;
        else if (cnt < CW'(FIFO_DEPTH / 2))
            rts_d = 1'b0;
    end

    assign count_o     = cnt;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign rts_o       = rts_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand-written multi-frame sequences.
module tb_uart_rx_fifo;
    localparam int CPB    = 138;
    localparam int PUSH_C = 3 + CPB/2 + 9*CPB;

    logic       clk = 1'b0;
    logic       reset_n_i, rx_i, ready_i, clear_i;
    logic       rts_o, valid_o, frame_err_o, overrun_o;
    logic [7:0] data_o;
    logic [4:0] count_o;

    int total = 0;
    int bad   = 0;
    int ferr_cnt = 0;
    int first_vld;

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        int         gap;
        logic       exp_vld;
        logic [7:0] exp_dat;
        int         exp_cnt;
        int         exp_ferr;
        int         exp_lat;
    } vec_t;
    vec_t vecs[4];

    uart_rx_fifo dut (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .rx_i        (rx_i),
        .rts_o       (rts_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .count_o     (count_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clear_i     (clear_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] dat, input logic stop, input int gap, input bit pop_at_push);
        logic [9:0] bits;
        bits = {stop, dat, 1'b0};
        first_vld = -1;
        for (int c = 0; c < 10*CPB + gap; c++) begin
            @(posedge clk);
            #1;
            rx_i = (c < 10*CPB) ? bits[c/CPB] : 1'b1;
            if (pop_at_push)
                ready_i = (c == PUSH_C - 1);
            @(negedge clk);
            if (frame_err_o)
                ferr_cnt++;
            if (valid_o && first_vld < 0)
                first_vld = c;
        end
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        @(negedge clk);
        check({nm, " vld"}, {31'd0, valid_o}, 32'd1);
        check(nm, {24'd0, data_o}, {24'd0, exp});
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && valid_o; i++) begin
            @(negedge clk);
            ready_i = 1'b1;
            @(negedge clk);
            ready_i = 1'b0;
        end
        check("drain empty", {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        int f0;
        logic [7:0] exp_b;
        logic [9:0] bits;

        vecs[0] = '{dat: 8'h55, stop: 1'b1, gap: 20,  exp_vld: 1'b1, exp_dat: 8'h55, exp_cnt: 1, exp_ferr: 0, exp_lat: PUSH_C};
        vecs[1] = '{dat: 8'h3C, stop: 1'b0, gap: 300, exp_vld: 1'b0, exp_dat: 8'h00, exp_cnt: 0, exp_ferr: 1, exp_lat: -1};
        vecs[2] = '{dat: 8'h12, stop: 1'b1, gap: 20,  exp_vld: 1'b1, exp_dat: 8'h12, exp_cnt: 1, exp_ferr: 0, exp_lat: PUSH_C};
        vecs[3] = '{dat: 8'hC6, stop: 1'b1, gap: 20,  exp_vld: 1'b1, exp_dat: 8'hC6, exp_cnt: 1, exp_ferr: 0, exp_lat: PUSH_C};

        rx_i = 1'b1; ready_i = 1'b0; clear_i = 1'b0; reset_n_i = 1'b1;
        #1 reset_n_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst count", {27'd0, count_o}, 32'd0);
        check("rst valid", {31'd0, valid_o}, 32'd0);
        check("rst data", {24'd0, data_o}, 32'd0);
        check("rst ferr", {31'd0, frame_err_o}, 32'd0);
        check("rst ovr", {31'd0, overrun_o}, 32'd0);
        check("rst rts", {31'd0, rts_o}, 32'd1);
        reset_n_i = 1'b1;
        @(negedge clk);
        check("rts after release", {31'd0, rts_o}, 32'd0);
        repeat (5) @(negedge clk);

        // Single-frame table
        for (int v = 0; v < 4; v++) begin
            drain();
            f0 = ferr_cnt;
            send_frame(vecs[v].dat, vecs[v].stop, vecs[v].gap, 1'b0);
            check($sformatf("v%0d valid", v), {31'd0, valid_o}, {31'd0, vecs[v].exp_vld});
            check($sformatf("v%0d data", v), {24'd0, data_o}, {24'd0, vecs[v].exp_dat});
            check($sformatf("v%0d count", v), {27'd0, count_o}, vecs[v].exp_cnt);
            check($sformatf("v%0d ferr pulses", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("v%0d latency", v), first_vld, vecs[v].exp_lat);
            check($sformatf("v%0d rts", v), {31'd0, rts_o}, 32'd0);
        end
        drain();

        // Back-to-back frames, no idle gap
        f0 = ferr_cnt;
        send_frame(8'hA3, 1'b1, 0, 1'b0);
        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 20, 1'b0);
        check("b2b count", {27'd0, count_o}, 32'd3);
        check("b2b ferr", ferr_cnt - f0, 32'd0);
        pop_chk("b2b pop0", 8'hA3);
        pop_chk("b2b pop1", 8'h00);
        pop_chk("b2b pop2", 8'hFF);
        check("b2b empty", {31'd0, valid_o}, 32'd0);

        // Short low glitch on idle line is a false start
        f0 = ferr_cnt;
        for (int c = 0; c < 340; c++) begin
            @(posedge clk);
            #1 rx_i = (c < 40) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (frame_err_o) ferr_cnt++;
        end
        check("glitch count", {27'd0, count_o}, 32'd0);
        check("glitch ferr", ferr_cnt - f0, 32'd0);
        send_frame(8'h5A, 1'b1, 20, 1'b0);
        check("post-glitch data", {24'd0, data_o}, 32'h5A);
        drain();

        // Flow control and overrun
        for (int i = 0; i < 11; i++)
            send_frame(8'h10 + 8'(i), 1'b1, 20, 1'b0);
        check("flow 11 rts", {31'd0, rts_o}, 32'd0);
        send_frame(8'h1B, 1'b1, 20, 1'b0);
        check("flow 12 count", {27'd0, count_o}, 32'd12);
        check("flow 12 rts", {31'd0, rts_o}, 32'd1);
        for (int i = 12; i < 16; i++)
            send_frame(8'h10 + 8'(i), 1'b1, 20, 1'b0);
        check("flow 16 count", {27'd0, count_o}, 32'd16);
        check("flow 16 ovr", {31'd0, overrun_o}, 32'd0);
        send_frame(8'h20, 1'b1, 20, 1'b0);
        check("flow 17 count", {27'd0, count_o}, 32'd16);
        check("flow 17 ovr", {31'd0, overrun_o}, 32'd1);
        check("flow head", {24'd0, data_o}, 32'h10);
        for (int i = 0; i < 8; i++)
            pop_chk($sformatf("flow pop%0d", i), 8'h10 + 8'(i));
        check("pop8 count", {27'd0, count_o}, 32'd8);
        check("pop8 rts held", {31'd0, rts_o}, 32'd1);
        pop_chk("flow pop8", 8'h18);
        check("pop9 count", {27'd0, count_o}, 32'd7);
        check("pop9 rts registered", {31'd0, rts_o}, 32'd1);
        @(negedge clk);
        check("pop9 rts cleared", {31'd0, rts_o}, 32'd0);
        check("ovr sticky", {31'd0, overrun_o}, 32'd1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("ovr cleared", {31'd0, overrun_o}, 32'd0);

        // Full FIFO with pop coinciding with push
        for (int i = 0; i < 9; i++)
            send_frame(8'h21 + 8'(i), 1'b1, 20, 1'b0);
        check("full count", {27'd0, count_o}, 32'd16);
        send_frame(8'h77, 1'b1, 20, 1'b1);
        check("pushpop count", {27'd0, count_o}, 32'd16);
        check("pushpop ovr", {31'd0, overrun_o}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 6) ? 8'h1A + 8'(i) : (i < 15) ? 8'h21 + 8'(i - 6) : 8'h77;
            pop_chk($sformatf("full pop%0d", i), exp_b);
        end
        check("full drained", {31'd0, valid_o}, 32'd0);

        // Reset in the middle of data bit 4
        send_frame(8'h42, 1'b1, 20, 1'b0);
        check("pre-reset count", {27'd0, count_o}, 32'd1);
        bits = {1'b1, 8'hC3, 1'b0};
        for (int c = 0; c < 5*CPB + 60; c++) begin
            @(posedge clk);
            #1 rx_i = bits[c/CPB];
        end
        #2 reset_n_i = 1'b0;
        #1;
        check("midrst count", {27'd0, count_o}, 32'd0);
        check("midrst valid", {31'd0, valid_o}, 32'd0);
        check("midrst data", {24'd0, data_o}, 32'd0);
        check("midrst rts", {31'd0, rts_o}, 32'd1);
        check("midrst ferr", {31'd0, frame_err_o}, 32'd0);
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;
        f0 = ferr_cnt;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (frame_err_o) ferr_cnt++;
        end
        check("postrst count", {27'd0, count_o}, 32'd0);
        send_frame(8'h81, 1'b1, 20, 1'b0);
        check("postrst data", {24'd0, data_o}, 32'h81);
        check("postrst cnt", {27'd0, count_o}, 32'd1);
        check("postrst ferr", ferr_cnt - f0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Board-side UART receiver with a byte FIFO and hardware RTS flow control.
- Sits between the PMOD rxd/rts pins and the SoC core, in place of the tied-high RTS.
- Samples the serial line, assembles 8N1 frames and buffers the bytes.
- Throttles the host via rts_o before the FIFO overflows.

Parameters:
- FREQ_HZ, 16000000, system clock frequency in Hz.
- BAUDS, 115200, serial bit rate. CLKS_PER_BIT = FREQ_HZ/BAUDS, integer division; 138 at the defaults.
- FIFO_DEPTH, 16, FIFO entries. Must be a power of two, 4 or greater.
- RTS_MARGIN, 4, free entries remaining when rts_o asserts. Must be 1 or greater and less than FIFO_DEPTH/2.

Ports:
- clk, input, 1, system clock; all logic is on its rising edge.
- reset_n_i, input, 1, reset. Asynchronous assert, active-low, one clock domain.
- rx_i, input, 1, serial data. Asynchronous to clk; idle level is high.
- rts_o, output, 1, flow control. 0 = host may send, 1 = host must stop.
- data_o, output, 8, FIFO head byte, first-word-fall-through.
- valid_o, output, 1, FIFO is non-empty; data_o is meaningful.
- ready_i, input, 1, consumer pop. A pop occurs when valid_o and ready_i are both 1.
- count_o, output, $clog2(FIFO_DEPTH+1), current FIFO occupancy.
- frame_err_o, output, 1, one-cycle pulse when a stop bit is sampled low.
- overrun_o, output, 1, sticky; set when a byte is dropped because the FIFO is full.
- clear_i, input, 1, synchronous clear of overrun_o.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - FSM goes to IDLE; FIFO is emptied; count_o=0, valid_o=0, data_o=0.
  - frame_err_o=0, overrun_o=0, rts_o=1.
  - The synchroniser flops reset to 1.
  - rts_o falls to 0 on the first clk edge after reset release.
- Input conditioning: rx_i passes through a 2-FF synchroniser; all decisions use the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP. One bit-timer counts 0..CLKS_PER_BIT-1. A 3-bit index counts data bits.
- IDLE: when rxs=0, clear the timer and go to START.
- START: at timer = CLKS_PER_BIT/2 - 1, sample rxs.
  - rxs=1: false start; return to IDLE. No output effect.
  - rxs=0: clear the timer and go to DATA.
- DATA: sample at every timer wrap (CLKS_PER_BIT clocks). Shift into the byte LSB-first. After bit 7, go to STOP.
- STOP: sample at timer wrap.
  - rxs=1: push the byte.
  - rxs=0: pulse frame_err_o for one cycle and discard the byte.
  - In both cases go to IDLE in the same cycle. This is half a bit before the stop-bit end, so a back-to-back start is never missed.
- Push latency: the byte appears on data_o and valid_o goes 1 on the clk edge after the stop-bit sample (FIFO previously empty). Total latency is about 9.5 bit times plus 3 clocks from the start-bit falling edge on rx_i.
- FIFO:
  - Circular buffer with read and write pointers; wrap is modulo FIFO_DEPTH.
  - count_o tracks occupancy exactly: push only +1, pop only -1, both 0.
- Simultaneous push and pop:
  - At any occupancy, both are performed; count is unchanged.
  - When full, the push is accepted because the pop frees the slot; no overrun.
  - When empty, no pop can occur (valid_o=0), so only the push happens.
- Overrun: a push while count=FIFO_DEPTH with no concurrent pop drops the byte and sets overrun_o.
  - FIFO contents and pointers are unchanged.
  - clear_i=1 clears overrun_o next cycle. If a set and clear_i coincide, the set wins.
- Pop with ready_i=1 and valid_o=0 is ignored.
- rts_o hysteresis, registered (one cycle after count changes):
  - Set to 1 when count_o >= FIFO_DEPTH - RTS_MARGIN.
  - Cleared to 0 when count_o < FIFO_DEPTH/2.
  - Otherwise holds its value.
- Reset mid-frame aborts the frame. After release the FSM waits for a fresh high-to-low edge; a line still low causes an immediate START.

Test Plan:
- Reset, then rx_i sends 0x55 at 115200 baud (138 clocks per bit) -> data_o=0x55 and valid_o=1 on the cycle after the stop sample. count_o=1, rts_o=0, frame_err_o never pulses.
- Back-to-back frames 0xA3, 0x00, 0xFF with no idle gap, ready_i=0 -> count_o=3. Popping with ready_i=1 yields 0xA3, 0x00, 0xFF in order, then valid_o=0.
- 0x3C sent with the stop bit forced low -> frame_err_o high for exactly one cycle, count_o stays 0. Next valid frame 0x12 is received correctly.
- A 40-clock low glitch on idle rx_i -> no push, no frame_err_o, FSM back in IDLE.
- ready_i=0, send 12 bytes -> rts_o=1 after byte 12 (count 12 = 16-4). Send 5 more -> count_o=16, overrun_o=1 after byte 17, head still byte 1. Pop 9 -> rts_o=0 once count_o reaches 7. clear_i -> overrun_o=0.
- FIFO full, and a pop coincides with a push of 0x77 -> count_o stays 16, overrun_o stays 0, 0x77 is the last byte read out.
- reset_n_i pulsed low during bit 4 of a frame -> all outputs at reset values immediately. The partial frame is not pushed, and the next full frame 0x81 is received correctly.
